// File: rtl/signed_saturate_narrow.sv
// Narrowing stage: round-half-up drop of reduction_size LSBs, then saturate to out_size bits.
// Two-stage elastic valid/ready pipeline, plus a clip counter and a held clip LED.
module signed_saturate_narrow #(
   parameter int operand_size     = 16,
   parameter int reduction_size   = 4,
   parameter int clip_hold_cycles = 4_800_000
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [operand_size-1:0]                in_sample,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [operand_size-reduction_size-1:0] out_sample,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   out_clip,
   input  logic                                   clear_clip,
   output logic [15:0]                            clip_count,
   output logic                                   clip_led
);

   localparam int out_size = operand_size - reduction_size;
   localparam int hold_w   = $clog2(clip_hold_cycles + 1);
   localparam logic [hold_w-1:0]       hold_load = hold_w'(clip_hold_cycles);
   localparam logic signed [operand_size:0] round_k =
      (operand_size + 1)'(1) << (reduction_size - 1);

   logic                          s1_valid_q, s1_valid_d;
   logic signed [out_size:0]      s1_q, s1_d;
   logic                          out_valid_q, out_valid_d;
   logic [out_size-1:0]           out_sample_q, out_sample_d;
   logic                          out_clip_q, out_clip_d;
   logic [15:0]                   clip_count_q, clip_count_d;
   logic [hold_w-1:0]             hold_q, hold_d;

   logic signed [operand_size:0]  sum;
   logic [out_size-1:0]           sat_val;
   logic                          sat_clip;
   logic                          s2_ready;
   logic                          clip_xfer;

   // Sign-extended by one bit so adding the half-LSB can never wrap.
   assign sum = $signed({in_sample[operand_size-1], in_sample}) + round_k;

   assign s2_ready  = !out_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || s2_ready;
   assign clip_xfer = out_valid_q && out_ready && out_clip_q;

   // Out of range exactly when the two top bits of the stage-1 value disagree.
   always_comb begin
      sat_val  = s1_q[out_size-1:0];
      sat_clip = 1'b0;
      if (s1_q[out_size] != s1_q[out_size-1]) begin
         sat_clip = 1'b1;
         sat_val  = s1_q[out_size] ? {1'b1, {(out_size-1){1'b0}}}
                                   : {1'b0, {(out_size-1){1'b1}}};
      end
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_d         = s1_q;
      out_valid_d  = out_valid_q;
      out_sample_d = out_sample_q;
      out_clip_d   = out_clip_q;
      clip_count_d = clip_count_q;
      hold_d       = hold_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         s1_d       = (out_size + 1)'(sum >>> reduction_size);
      end
      if (s2_ready) begin
         out_valid_d  = s1_valid_q;
         out_sample_d = sat_val;
         out_clip_d   = sat_clip;
      end

      if (clear_clip) begin
         clip_count_d = '0;
         hold_d       = '0;
      end else begin
         if (clip_xfer && clip_count_q != 16'hFFFF)
            clip_count_d = clip_count_q + 16'd1;
         if (clip_xfer)
            hold_d = hold_load;
         else if (hold_q != '0)
            hold_d = hold_q - hold_w'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_q         <= '0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         out_clip_q   <= 1'b0;
         clip_count_q <= '0;
         hold_q       <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_q         <= s1_d;
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         out_clip_q   <= out_clip_d;
         clip_count_q <= clip_count_d;
         hold_q       <= hold_d;
      end
   end

   assign out_sample = out_sample_q;
   assign out_valid  = out_valid_q;
   assign out_clip   = out_clip_q;
   assign clip_count = clip_count_q;
   assign clip_led   = (hold_q != '0);

endmodule
